// File: rtl/rob_buffer.sv
// -----------------------------------------------------------------------------
// rob_buffer -- circular reorder buffer
//
// Allocates one entry per dispatched instruction at the tail and hands the
// entry index back to dispatch (alloc_idx). It records results from three
// functional-unit write-back ports. It retires the oldest entry in program
// order, at most one per cycle, once that entry has completed.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   alloc_valid/_ready    dispatch handshake; ready = not full
//   alloc_has_rd/_is_store/_rd_arch/_rd_preg/_old_preg
//                         fields captured into the tail entry
//   alloc_idx             current tail index (valid at all times)
//   cmpl_valid[2:0]       per-port completion strobes
//   cmpl_idx              packed indices, port k at [k*IDX_WIDTH +: IDX_WIDTH]
//   cmpl_value            packed results, port k at [k*32 +: 32]
//   retire_valid/_ready   retire handshake for the head entry
//   retire_*              head entry fields, forced to 0 when not retiring
//   count, empty          occupancy
// -----------------------------------------------------------------------------
module rob_buffer #(
  parameter int PREG_WIDTH = 6,
  parameter int AREG_WIDTH = 5,
  parameter int DEPTH      = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // dispatch / allocate
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic                    alloc_has_rd,
  input  logic                    alloc_is_store,
  input  logic [AREG_WIDTH-1:0]   alloc_rd_arch,
  input  logic [PREG_WIDTH-1:0]   alloc_rd_preg,
  input  logic [PREG_WIDTH-1:0]   alloc_old_preg,
  output logic [IDX_WIDTH-1:0]    alloc_idx,
  // write-back completion
  input  logic [2:0]              cmpl_valid,
  input  logic [3*IDX_WIDTH-1:0]  cmpl_idx,
  input  logic [95:0]             cmpl_value,
  // retire
  output logic                    retire_valid,
  input  logic                    retire_ready,
  output logic                    retire_has_rd,
  output logic                    retire_is_store,
  output logic [AREG_WIDTH-1:0]   retire_arch,
  output logic [PREG_WIDTH-1:0]   retire_preg,
  output logic [PREG_WIDTH-1:0]   retire_old_preg,
  output logic [31:0]             retire_value,
  // occupancy
  output logic [IDX_WIDTH:0]      count,
  output logic                    empty
);

  localparam int NPORTS = 3;
  localparam int PTR_W  = IDX_WIDTH + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index fields match.
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;

  // Per-entry control state (reset).
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     done_q,  done_d;

  // Per-entry payload (not reset).
  logic                  has_rd_q   [DEPTH];
  logic                  is_store_q [DEPTH];
  logic [AREG_WIDTH-1:0] arch_q     [DEPTH];
  logic [PREG_WIDTH-1:0] preg_q     [DEPTH];
  logic [PREG_WIDTH-1:0] old_preg_q [DEPTH];
  logic [31:0]           value_q    [DEPTH];

  logic [IDX_WIDTH-1:0] head_idx;
  logic [IDX_WIDTH-1:0] tail_idx;
  logic                 full;
  logic                 alloc_fire;
  logic                 retire_fire;

  // Unpacked view of the completion ports.
  logic [IDX_WIDTH-1:0] c_idx [NPORTS];
  logic [31:0]          c_val [NPORTS];
  logic [NPORTS-1:0]    c_hit;

  // ---------------------------------------------------------------------------
  // Pointer-derived status
  // ---------------------------------------------------------------------------
  assign head_idx = head_q[IDX_WIDTH-1:0];
  assign tail_idx = tail_q[IDX_WIDTH-1:0];

  assign full  = (head_idx == tail_idx) && (head_q[IDX_WIDTH] != tail_q[IDX_WIDTH]);
  assign empty = (head_q == tail_q);
  assign count = tail_q - head_q;

  // alloc_ready looks only at registered pointers, so a retire in the same
  // cycle never frees a slot for a simultaneous allocate.
  assign alloc_ready = !full;
  assign alloc_idx   = tail_idx;
  assign alloc_fire  = alloc_valid && !full;

  assign retire_valid = valid_q[head_idx] && done_q[head_idx];
  assign retire_fire  = retire_valid && retire_ready;

  // ---------------------------------------------------------------------------
  // Completion decode: a write only counts if its target is currently live.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NPORTS; k++) begin
      c_idx[k] = cmpl_idx[k*IDX_WIDTH +: IDX_WIDTH];
      c_val[k] = cmpl_value[k*32 +: 32];
      c_hit[k] = cmpl_valid[k] && valid_q[c_idx[k]];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state for pointers and control bits
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;

    for (int k = 0; k < NPORTS; k++) begin
      if (c_hit[k]) begin
        done_d[c_idx[k]] = 1'b1;
      end
    end

    // Retire is applied after completion so a late write to the retiring
    // head cannot leave a stale done bit in the freed slot.
    if (retire_fire) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end

    // The tail slot is never live (alloc is blocked when full), so this
    // cannot collide with the retire clear above.
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload array has no reset; every read of it is qualified by a
  // reset valid/done bit, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_rd_q[tail_idx]   <= alloc_has_rd;
      is_store_q[tail_idx] <= alloc_is_store;
      arch_q[tail_idx]     <= alloc_rd_arch;
      preg_q[tail_idx]     <= alloc_rd_preg;
      old_preg_q[tail_idx] <= alloc_old_preg;
    end
    // NOTE: with non-blocking assignments the last one scheduled wins, so
    // iterating ports in ascending order gives the highest port priority
    // when several ports hit the same entry.
    for (int k = 0; k < NPORTS; k++) begin
      if (c_hit[k]) begin
        value_q[c_idx[k]] <= c_val[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retire outputs: head fields, zeroed whenever the head cannot retire.
  // ---------------------------------------------------------------------------
  always_comb begin
    retire_has_rd   = 1'b0;
    retire_is_store = 1'b0;
    retire_arch     = '0;
    retire_preg     = '0;
    retire_old_preg = '0;
    retire_value    = '0;
    if (retire_valid) begin
      retire_has_rd   = has_rd_q[head_idx];
      retire_is_store = is_store_q[head_idx];
      retire_arch     = arch_q[head_idx];
      retire_preg     = preg_q[head_idx];
      retire_old_preg = old_preg_q[head_idx];
      retire_value    = value_q[head_idx];
    end
  end

endmodule

// File: tb/tb_rob_buffer.sv
// -----------------------------------------------------------------------------
// tb_rob_buffer -- self-checking bench for rob_buffer
//
// Directed scenarios plus a randomized stress run. The stress run uses a
// reference model: an in-order queue of instruction records. Indices are
// handed out round-robin modulo 16, and only the queue front may retire once
// it has completed. Outputs are sampled 1 time unit after each rising edge.
// Inputs are also driven at that point.
// -----------------------------------------------------------------------------
module tb_rob_buffer;

  localparam int PW = 6;
  localparam int AW = 5;
  localparam int D  = 16;
  localparam int IW = 4;

  logic          clk;
  logic          rst_n;
  logic          alloc_valid;
  logic          alloc_ready;
  logic          alloc_has_rd;
  logic          alloc_is_store;
  logic [AW-1:0] alloc_rd_arch;
  logic [PW-1:0] alloc_rd_preg;
  logic [PW-1:0] alloc_old_preg;
  logic [IW-1:0] alloc_idx;
  logic [2:0]    cmpl_valid;
  logic [3*IW-1:0] cmpl_idx;
  logic [95:0]   cmpl_value;
  logic          retire_valid;
  logic          retire_ready;
  logic          retire_has_rd;
  logic          retire_is_store;
  logic [AW-1:0] retire_arch;
  logic [PW-1:0] retire_preg;
  logic [PW-1:0] retire_old_preg;
  logic [31:0]   retire_value;
  logic [IW:0]   count;
  logic          empty;

  int errors = 0;
  int checks = 0;

  rob_buffer #(.PREG_WIDTH(PW), .AREG_WIDTH(AW), .DEPTH(D), .IDX_WIDTH(IW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_has_rd   (alloc_has_rd),
    .alloc_is_store (alloc_is_store),
    .alloc_rd_arch  (alloc_rd_arch),
    .alloc_rd_preg  (alloc_rd_preg),
    .alloc_old_preg (alloc_old_preg),
    .alloc_idx      (alloc_idx),
    .cmpl_valid     (cmpl_valid),
    .cmpl_idx       (cmpl_idx),
    .cmpl_value     (cmpl_value),
    .retire_valid   (retire_valid),
    .retire_ready   (retire_ready),
    .retire_has_rd  (retire_has_rd),
    .retire_is_store(retire_is_store),
    .retire_arch    (retire_arch),
    .retire_preg    (retire_preg),
    .retire_old_preg(retire_old_preg),
    .retire_value   (retire_value),
    .count          (count),
    .empty          (empty)
  );

  // All retire outputs as one vector: {valid, has_rd, is_store, arch, preg, old, value}.
  logic [51:0] ret_bus;
  assign ret_bus = {retire_valid, retire_has_rd, retire_is_store, retire_arch,
                    retire_preg, retire_old_preg, retire_value};

  // The expected retire vector: fields when retiring, all zero otherwise.
  function automatic logic [51:0] exp_ret(input logic rv, input logic hr, input logic st,
                                          input logic [AW-1:0] ar, input logic [PW-1:0] pr,
                                          input logic [PW-1:0] op, input logic [31:0] v);
    return rv ? {1'b1, hr, st, ar, pr, op, v} : 52'd0;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid    = 1'b0;
    alloc_has_rd   = 1'b0;
    alloc_is_store = 1'b0;
    alloc_rd_arch  = '0;
    alloc_rd_preg  = '0;
    alloc_old_preg = '0;
    cmpl_valid     = '0;
    cmpl_idx       = '0;
    cmpl_value     = '0;
    retire_ready   = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    cycle();
  endtask

  task automatic drive_alloc(input logic [AW-1:0] ar, input logic [PW-1:0] pr,
                             input logic [PW-1:0] op, input logic hr, input logic st);
    alloc_valid    = 1'b1;
    alloc_rd_arch  = ar;
    alloc_rd_preg  = pr;
    alloc_old_preg = op;
    alloc_has_rd   = hr;
    alloc_is_store = st;
  endtask

  task automatic set_cmpl(input int p, input logic [IW-1:0] idx, input logic [31:0] v);
    cmpl_valid[p]         = 1'b1;
    cmpl_idx[p*IW +: IW]  = idx;
    cmpl_value[p*32 +: 32] = v;
  endtask

  // ---------------------------------------------------------------------------
  // Reset: asserted in the middle of a cycle with live, retirable entries.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(AW'(i + 1), PW'(i + 4), PW'(i + 8), 1'b1, 1'b1);
      cycle();
    end
    alloc_valid = 1'b0;
    set_cmpl(0, 4'd0, 32'h1234);
    cycle();
    cmpl_valid = '0;
    // Now at edge+1: three entries live and the head retirable.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b exp 1", empty); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b exp 1", alloc_ready); end
    checks++; if (alloc_idx !== 4'd0) begin errors++; $display("FAIL reset_alloc_idx: got %0d exp 0", alloc_idx); end
    checks++; if (ret_bus !== 52'd0) begin errors++; $display("FAIL reset_retire_bus: got %h exp 0", ret_bus); end
    // Hold reset across an edge with an allocate request; nothing may stick.
    alloc_valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    alloc_valid = 1'b0;
    cycle();
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL reset_release: got count %0d empty %0b exp 0/1", count, empty);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Out-of-order completion, in-order retire.
  // ---------------------------------------------------------------------------
  task automatic test_in_order();
    apply_reset();
    retire_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alloc(AW'(i + 1), PW'(10 + i), PW'(20 + i), 1'b1, 1'b0);
      checks++; if (alloc_idx !== IW'(i)) begin errors++; $display("FAIL inorder_alloc_idx: got %0d exp %0d", alloc_idx, i); end
      cycle();
    end
    alloc_valid = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL inorder_count: got %0d exp 3", count); end
    for (int j = 0; j < 3; j++) begin
      set_cmpl(0, IW'(2 - j), 32'hC - 32'(j));
      cycle();
      cmpl_valid = '0;
      if (j < 2) begin
        checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL inorder_early_retire: got %0b exp 0 after cmpl %0d", retire_valid, 2 - j); end
      end
    end
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (ret_bus !== exp_ret(1'b1, 1'b1, 1'b0, AW'(r + 1), PW'(10 + r), PW'(20 + r), 32'hA + 32'(r))) begin
        errors++; $display("FAIL inorder_retire%0d: got %h exp value %h", r, ret_bus, 32'hA + 32'(r));
      end
      cycle();
    end
    checks++; if (retire_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL inorder_drained: got rv %0b empty %0b exp 0/1", retire_valid, empty);
    end
    retire_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Full boundary: retire while full does not admit an allocate that cycle.
  // ---------------------------------------------------------------------------
  task automatic test_full();
    apply_reset();
    for (int i = 0; i < D; i++) begin
      drive_alloc(AW'(i), PW'(i + 1), PW'(i), 1'b1, i[0]);
      cycle();
    end
    alloc_valid = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d exp 16", count); end
    checks++; if (alloc_ready !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL full_ready: got ready %0b empty %0b exp 0/0", alloc_ready, empty);
    end
    set_cmpl(1, 4'd0, 32'h500);
    cycle();
    cmpl_valid = '0;
    checks++; if (retire_valid !== 1'b1 || retire_value !== 32'h500) begin
      errors++; $display("FAIL full_head_done: got rv %0b value %h exp 1/500", retire_valid, retire_value);
    end
    drive_alloc(5'd7, 6'h3F, 6'h3F, 1'b1, 1'b0);
    retire_ready = 1'b1;
    cycle();
    retire_ready = 1'b0;
    checks++; if (count !== 5'd15 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
      errors++; $display("FAIL full_retire_no_alloc: got count %0d ready %0b idx %0d exp 15/1/0", count, alloc_ready, alloc_idx);
    end
    cycle();
    alloc_valid = 1'b0;
    checks++; if (count !== 5'd16 || alloc_ready !== 1'b0 || alloc_idx !== 4'd1) begin
      errors++; $display("FAIL full_wrap_alloc: got count %0d ready %0b idx %0d exp 16/0/1", count, alloc_ready, alloc_idx);
    end
    for (int k = 1; k <= D; k++) begin
      set_cmpl(k % 3, IW'(k % D), 32'h600 + 32'(k));
      cycle();
      cmpl_valid = '0;
    end
    retire_ready = 1'b1;
    for (int k = 1; k <= D; k++) begin
      checks++;
      if (retire_valid !== 1'b1 || retire_old_preg !== ((k < D) ? PW'(k) : 6'h3F) ||
          retire_value !== 32'h600 + 32'(k)) begin
        errors++; $display("FAIL full_drain%0d: got rv %0b old %0d value %h", k, retire_valid, retire_old_preg, retire_value);
      end
      cycle();
    end
    retire_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: got empty %0b exp 1", empty); end
  endtask

  // ---------------------------------------------------------------------------
  // Same-index completions and completions to dead entries.
  // ---------------------------------------------------------------------------
  task automatic test_simul_cmpl();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive_alloc(AW'(i), PW'(40 + i), PW'(30 + i), 1'b0, 1'b0);
      cycle();
    end
    alloc_valid = 1'b0;
    set_cmpl(0, 4'd9, 32'h999);
    cycle();
    cmpl_valid = '0;
    checks++; if (retire_valid !== 1'b0 || count !== 5'd9) begin
      errors++; $display("FAIL simul_dead_idx9: got rv %0b count %0d exp 0/9", retire_valid, count);
    end
    set_cmpl(0, 4'd5, 32'd1);
    set_cmpl(1, 4'd5, 32'd2);
    set_cmpl(2, 4'd5, 32'd3);
    cycle();
    cmpl_valid = '0;
    for (int i = 0; i < 9; i++) begin
      if (i != 5) begin
        set_cmpl(0, IW'(i), 32'h100 + 32'(i));
        cycle();
        cmpl_valid = '0;
      end
    end
    retire_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ret_bus !== exp_ret(1'b1, 1'b0, 1'b0, AW'(i), PW'(40 + i), PW'(30 + i),
                              (i == 5) ? 32'd3 : 32'h100 + 32'(i))) begin
        errors++; $display("FAIL simul_retire%0d: got %h", i, ret_bus);
      end
      cycle();
    end
    checks++; if (empty !== 1'b1 || alloc_idx !== 4'd9) begin
      errors++; $display("FAIL simul_drained: got empty %0b idx %0d exp 1/9", empty, alloc_idx);
    end
    // Entry 9 is free: a completion must not make it retirable or count.
    set_cmpl(2, 4'd9, 32'h77);
    cycle();
    cmpl_valid = '0;
    checks++; if (retire_valid !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL simul_dead_empty: got rv %0b count %0d exp 0/0", retire_valid, count);
    end
    drive_alloc(5'd2, 6'd2, 6'd3, 1'b1, 1'b0);
    cycle();
    alloc_valid = 1'b0;
    checks++; if (retire_valid !== 1'b0 || count !== 5'd1) begin
      errors++; $display("FAIL simul_fresh_not_done: got rv %0b count %0d exp 0/1", retire_valid, count);
    end
    set_cmpl(1, 4'd9, 32'h88);
    cycle();
    cmpl_valid = '0;
    checks++; if (retire_valid !== 1'b1 || retire_value !== 32'h88) begin
      errors++; $display("FAIL simul_fresh_done: got rv %0b value %h exp 1/88", retire_valid, retire_value);
    end
    cycle();
    retire_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_final_empty: got %0b exp 1", empty); end
  endtask

  // ---------------------------------------------------------------------------
  // Backpressure: stalled head keeps every retire output stable.
  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    apply_reset();
    drive_alloc(5'd3, 6'h21, 6'h12, 1'b1, 1'b1);
    cycle();
    drive_alloc(5'd4, 6'h22, 6'h13, 1'b1, 1'b0);
    cycle();
    alloc_valid = 1'b0;
    set_cmpl(2, 4'd0, 32'hDEAD_BEEF);
    cycle();
    cmpl_valid = '0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ret_bus !== exp_ret(1'b1, 1'b1, 1'b1, 5'd3, 6'h21, 6'h12, 32'hDEAD_BEEF) || count !== 5'd2) begin
        errors++; $display("FAIL bp_stall%0d: got %h count %0d", c, ret_bus, count);
      end
      cycle();
    end
    retire_ready = 1'b1;
    cycle();
    retire_ready = 1'b0;
    checks++; if (count !== 5'd1 || ret_bus !== 52'd0) begin
      errors++; $display("FAIL bp_accept: got count %0d bus %h exp 1/0", count, ret_bus);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized stress against an in-order queue model.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [IW-1:0] idx;
    logic [AW-1:0] arch;
    logic [PW-1:0] preg;
    logic [PW-1:0] old;
    logic          hr;
    logic          st;
    logic          done;
    logic [31:0]   value;
  } rec_t;

  task automatic test_wrap_stress();
    rec_t          q[$];
    rec_t          r;
    logic [PW-1:0] alloc_old_seq[$];
    logic [PW-1:0] retire_old_seq[$];
    int            allocated = 0;
    int            retired   = 0;
    int            cyc       = 0;
    int            tail_idx  = 0;
    logic          exp_rv;
    logic          a_fire;
    logic          r_fire;
    logic [IW-1:0] ci;
    logic [31:0]   cv;

    apply_reset();
    while (retired < 40 && cyc < 4000) begin
      exp_rv = (q.size() > 0) && q[0].done;
      checks++;
      if (count !== 5'(q.size()) || count > 5'd16 || alloc_ready !== (q.size() < D) ||
          alloc_idx !== IW'(tail_idx)) begin
        errors++; $display("FAIL stress_status cyc %0d: got count %0d ready %0b idx %0d exp %0d/%0b/%0d",
                           cyc, count, alloc_ready, alloc_idx, q.size(), q.size() < D, tail_idx);
      end
      checks++;
      if (exp_rv) begin
        if (ret_bus !== exp_ret(1'b1, q[0].hr, q[0].st, q[0].arch, q[0].preg, q[0].old, q[0].value)) begin
          errors++; $display("FAIL stress_retire cyc %0d: got %h exp old %0d value %h", cyc, ret_bus, q[0].old, q[0].value);
        end
      end else if (ret_bus !== 52'd0) begin
        errors++; $display("FAIL stress_retire_idle cyc %0d: got %h exp 0", cyc, ret_bus);
      end

      // Random stimulus for the coming edge.
      if (allocated < 40 && $urandom_range(3) != 0) begin
        drive_alloc(AW'($urandom), PW'($urandom), PW'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        alloc_valid = 1'b0;
      end
      cmpl_valid = '0;
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(2) == 0) begin
          if (q.size() > 0 && $urandom_range(3) != 0) ci = q[$urandom_range(q.size() - 1)].idx;
          else ci = IW'($urandom_range(D - 1));
          set_cmpl(p, ci, $urandom);
        end
      end
      retire_ready = 1'($urandom_range(1));

      // Model update for this edge, decided from the pre-edge state.
      a_fire = alloc_valid && (q.size() < D);
      r_fire = retire_ready && exp_rv;
      if (r_fire) retire_old_seq.push_back(retire_old_preg);
      for (int p = 0; p < 3; p++) begin
        if (cmpl_valid[p]) begin
          ci = cmpl_idx[p*IW +: IW];
          cv = cmpl_value[p*32 +: 32];
          for (int j = 0; j < q.size(); j++) begin
            if (q[j].idx == ci) begin
              q[j].done  = 1'b1;
              q[j].value = cv;
            end
          end
        end
      end
      if (r_fire) begin
        void'(q.pop_front());
        retired++;
      end
      if (a_fire) begin
        r.idx = IW'(tail_idx); r.arch = alloc_rd_arch; r.preg = alloc_rd_preg;
        r.old = alloc_old_preg; r.hr = alloc_has_rd; r.st = alloc_is_store;
        r.done = 1'b0; r.value = '0;
        q.push_back(r);
        alloc_old_seq.push_back(alloc_old_preg);
        tail_idx = (tail_idx + 1) % D;
        allocated++;
      end
      cycle();
      cyc++;
    end
    idle_inputs();
    checks++; if (retired != 40) begin errors++; $display("FAIL stress_budget: got %0d retires exp 40", retired); end
    checks++;
    if (retire_old_seq.size() != 40 || alloc_old_seq.size() < 40) begin
      errors++; $display("FAIL stress_old_seq_len: got %0d exp 40", retire_old_seq.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        if (retire_old_seq[i] !== alloc_old_seq[i]) begin
          errors++; $display("FAIL stress_old_seq[%0d]: got %0d exp %0d", i, retire_old_seq[i], alloc_old_seq[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    test_reset();
    test_in_order();
    test_full();
    test_simul_cmpl();
    test_backpressure();
    test_wrap_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
- Circular reorder buffer that sits beside the reservation station.
- At dispatch it allocates one entry per instruction and returns the ROB index that travels with the RS row.
- It records completions from up to three functional-unit write-back ports.
- It retires the oldest completed entry in program order, one per cycle, to the architectural-map and free-list logic.

Parameters:
- PREG_WIDTH, 6, physical register tag width.
- AREG_WIDTH, 5, architectural register index width.
- DEPTH, 16, number of entries; must be a power of 2, minimum 4.
- IDX_WIDTH, 4, entry index width; must equal log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  dispatch presents an instruction.
- alloc_ready  out  1  entry available (not full).
- alloc_has_rd  in  1  instruction writes a register.
- alloc_is_store  in  1  instruction is a store.
- alloc_rd_arch  in  AREG_WIDTH  destination architectural register.
- alloc_rd_preg  in  PREG_WIDTH  newly mapped physical register.
- alloc_old_preg  in  PREG_WIDTH  previous mapping, freed at retire.
- alloc_idx  out  IDX_WIDTH  index given to the allocating instruction (the current tail).
- cmpl_valid  in  3  per-port completion strobe.
- cmpl_idx  in  3*IDX_WIDTH  packed completion indices; port k uses bits [k*IDX_WIDTH +: IDX_WIDTH].
- cmpl_value  in  96  packed 32-bit results; port k uses bits [k*32 +: 32].
- retire_valid  out  1  head entry is done.
- retire_ready  in  1  consumer accepts the retiring entry.
- retire_has_rd  out  1  head field.
- retire_is_store  out  1  head field.
- retire_arch  out  AREG_WIDTH  head field.
- retire_preg  out  PREG_WIDTH  head field.
- retire_old_preg  out  PREG_WIDTH  head field.
- retire_value  out  32  head result.
- count  out  IDX_WIDTH+1  number of occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Storage: per entry {valid, done, has_rd, is_store, arch, preg, old_preg, value[31:0]}.
- Pointers: head_ptr and tail_ptr are IDX_WIDTH+1 bits wide; the MSB is a wrap bit.
  - full = (index bits equal) and (wrap bits differ).
  - empty = pointers equal.
- Reset (async, rst_n=0): all valid and done bits = 0, head_ptr = tail_ptr = 0. Consequent output values:
  - count = 0, empty = 1, alloc_ready = 1, alloc_idx = 0.
  - retire_valid = 0; all retire_* data outputs = 0.
  - Reset asserted mid-operation discards every in-flight entry.
- Allocate: alloc_ready = !full, combinational from the registered pointers. On a clk edge with alloc_valid & alloc_ready:
  - entry[tail] <= {valid=1, done=0, fields from alloc_*};
  - tail_ptr <= tail_ptr + 1.
  - alloc_idx = tail_ptr[IDX_WIDTH-1:0] at all times, so dispatch samples it in the same cycle as the handshake.
- Completion: on a clk edge, for each port k with cmpl_valid[k]:
  - if entry[cmpl_idx_k].valid, set done <= 1 and value <= cmpl_value_k;
  - otherwise ignore the write.
  - If two ports target the same index, the highest-numbered port's value is written.
- Retire (combinational):
  - retire_valid = entry[head].valid & entry[head].done.
  - retire_* data outputs show entry[head] fields whenever retire_valid = 1, and are 0 otherwise.
- Retire (sequential): on a clk edge with retire_valid & retire_ready:
  - entry[head].valid <= 0, entry[head].done <= 0;
  - head_ptr <= head_ptr + 1.
  - At most one retire per cycle.
- Completion to the head entry: retire_valid rises the following cycle. There is no same-cycle bypass; latency from completion to retire is 1 cycle minimum.
- Simultaneous allocate and retire:
  - Both occur; count is unchanged.
  - When full, allocate is refused in that cycle even if the head retires; alloc_ready is based on the pre-retire state.
  - When empty, allocate proceeds and nothing retires, because the new entry has done = 0.
- Wrap-around: pointers increment modulo 2*DEPTH; the index field wraps DEPTH-1 -> 0.
- Counter: count = tail_ptr - head_ptr, in IDX_WIDTH+1 bit modular arithmetic. count = DEPTH when full.
- A stalled retire (retire_ready = 0) holds the head and all retire outputs stable until it is accepted.

Test Plan:
- Reset: drive rst_n = 0 asynchronously mid-cycle -> count = 0, empty = 1, alloc_ready = 1, retire_valid = 0, alloc_idx = 0, with no dependence on clk.
- In-order retire: allocate idx 0,1,2 (rd_preg 10,11,12); complete idx 2 then 1 then 0 (values 0xC,0xB,0xA), retire_ready = 1.
  - Nothing retires until idx 0 is done.
  - Then 0,1,2 retire on consecutive cycles with values 0xA,0xB,0xC.
- Full boundary: allocate 16 entries -> alloc_ready = 0, count = 16.
  - Retire the head while alloc_valid = 1 -> no allocate that cycle.
  - Next cycle alloc_idx = 0 is accepted with the wrap bit toggled.
- Simultaneous completions: all three ports target idx 5 with values 1,2,3 -> entry 5 value = 3.
  - A completion to an unallocated idx 9 leaves entry 9 done = 0.
- Backpressure: head done, retire_ready = 0 for 4 cycles -> retire_valid and all retire_* outputs are constant; head_ptr advances only on the cycle retire_ready = 1.
- Wrap stress: 40 alloc/complete/retire operations with random completion order and random retire_ready.
  - Retire order matches allocation order.
  - retire_old_preg sequence equals the alloc_old_preg sequence.
  - count never exceeds 16.
